// File: rtl/mux16to1_reg_if.sv
// -----------------------------------------------------------------------------
// mux16to1_reg_if
//   Bundles the data/select/strobe inputs and the result outputs of
//   mux16to1_reg so the block and its environment share one port object.
//
//   Handshake: in_vld is a valid-only strobe with no ready. A sample is
//   accepted on every rising clk edge where in_vld=1. out_vld is high for
//   exactly the cycle after each accepted sample. There is no backpressure.
//
//   Signals
//     inp       [15:0]  data word; bit i is candidate i
//     sele      [3:0]   select index 0..15
//     in_vld            qualifies inp/sele for capture
//     outp              combinational inp[sele]
//     outp_q            registered inp[sele]
//     out_vld           outp_q holds a freshly captured value
//     sel_oh_q  [15:0]  registered one-hot of sele (only with MUX16TO1_ONEHOT_EN)
//
//   Modports
//     master : drives inp/sele/in_vld, observes results (testbench / upstream)
//     slave  : the mux block itself
//
//   Optional feature macro: MUX16TO1_ONEHOT_EN
// -----------------------------------------------------------------------------
interface mux16to1_reg_if;
    logic [15:0] inp;
    logic [3:0]  sele;
    logic        in_vld;
    logic        outp;
    logic        outp_q;
    logic        out_vld;
`ifdef MUX16TO1_ONEHOT_EN
    logic [15:0] sel_oh_q;
`endif

`ifdef MUX16TO1_ONEHOT_EN
    modport master (
        output inp, sele, in_vld,
        input  outp, outp_q, out_vld, sel_oh_q
    );
    modport slave (
        input  inp, sele, in_vld,
        output outp, outp_q, out_vld, sel_oh_q
    );
`else
    modport master (
        output inp, sele, in_vld,
        input  outp, outp_q, out_vld
    );
    modport slave (
        input  inp, sele, in_vld,
        output outp, outp_q, out_vld
    );
`endif
endinterface

// File: rtl/mux16to1_reg.sv
// -----------------------------------------------------------------------------
// mux16to1_reg
//   Single-bit 16:1 selector. outp is the combinational pick inp[sele];
//   outp_q is the same pick registered on clk when in_vld=1, with out_vld
//   marking the cycle in which outp_q holds a fresh sample.
//
//   Ports
//     clk    in   rising-edge clock
//     rst_n  in   asynchronous active-low reset
//     bus    slave modport of mux16to1_reg_if (inp, sele, in_vld,
//            outp, outp_q, out_vld [, sel_oh_q])
//
//   Parameters
//     RESET_VAL  value loaded into outp_q while rst_n=0
//
//   Optional feature macro: MUX16TO1_ONEHOT_EN
//     When defined, sel_oh_q is a registered one-hot decode of sele that
//     follows the same capture rules as outp_q and resets to 16'h0000.
//     When undefined, no decode logic is built.
//
//   There is no state machine; the only state is outp_q/out_vld (and
//   sel_oh_q when enabled).
// -----------------------------------------------------------------------------
module mux16to1_reg #(
    parameter logic RESET_VAL = 1'b0
) (
    input logic           clk,
    input logic           rst_n,
    mux16to1_reg_if.slave bus
);

    // Variable bit-select: an X/Z on sele or on the chosen bit propagates
    // to outp in simulation, which is the intended visibility.
    assign bus.outp = bus.inp[bus.sele];

    // outp_q holds across idle cycles; out_vld is a one-cycle marker.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.outp_q  <= RESET_VAL;
            bus.out_vld <= 1'b0;
        end else begin
            bus.out_vld <= bus.in_vld;
            if (bus.in_vld) begin
                bus.outp_q <= bus.inp[bus.sele];
            end
        end
    end

`ifdef MUX16TO1_ONEHOT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.sel_oh_q <= 16'h0000;
        end else if (bus.in_vld) begin
            bus.sel_oh_q <= 16'h0001 << bus.sele;
        end
    end
`endif

endmodule

// File: tb/tb_mux16to1_reg.sv
// -----------------------------------------------------------------------------
// tb_mux16to1_reg
//   Directed bench for mux16to1_reg: combinational pick, registered pick
//   with valid strobe, asynchronous reset, full select sweep, and the
//   one-hot decode output when MUX16TO1_ONEHOT_EN is defined.
// -----------------------------------------------------------------------------
module tb_mux16to1_reg;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    // Expected registered bits, pushed when a sample is driven and popped
    // after the capturing edge.
    logic [0:0]  exp_q[$];
    logic [15:0] word_q[$];

    mux16to1_reg_if bus ();

    mux16to1_reg #(.RESET_VAL(1'b0)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- driver tasks ----------------
    task automatic drive(input logic [15:0] w, input logic [3:0] s, input logic v);
        bus.inp    = w;
        bus.sele   = s;
        bus.in_vld = v;
    endtask

    // Advance past the next rising edge and settle before sampling.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        logic [15:0] words[2];
        logic [15:0] w;
        logic        e;

        checks = 0;
        errors = 0;
        words[0] = 16'hA5C3;
        words[1] = 16'h5A3C;

        rst_n = 1'b0;
        drive(16'h0000, 4'd0, 1'b0);
        #1;
        check("reset_outp_q", {15'b0, bus.outp_q}, 16'h0);
        check("reset_out_vld", {15'b0, bus.out_vld}, 16'h0);
`ifdef MUX16TO1_ONEHOT_EN
        check("reset_sel_oh_q", bus.sel_oh_q, 16'h0000);
`endif
        @(negedge clk);
        rst_n = 1'b1;

        // T1: 16'h3f0a -> bits 0..3 = 0,1,0,1
        drive(16'h3f0a, 4'd0, 1'b0); #1; check("t1_sel0", {15'b0, bus.outp}, 16'h0);
        drive(16'h3f0a, 4'd1, 1'b0); #1; check("t1_sel1", {15'b0, bus.outp}, 16'h1);
        drive(16'h3f0a, 4'd2, 1'b0); #1; check("t1_sel2", {15'b0, bus.outp}, 16'h0);
        drive(16'h3f0a, 4'd3, 1'b0); #1; check("t1_sel3", {15'b0, bus.outp}, 16'h1);
        // T2: bit13=1, bit15=0
        drive(16'h3f0a, 4'd13, 1'b0); #1; check("t2_sel13", {15'b0, bus.outp}, 16'h1);
        drive(16'h3f0a, 4'd15, 1'b0); #1; check("t2_sel15", {15'b0, bus.outp}, 16'h0);
        // Idle edge: no capture yet after reset
        tick();
        check("idle_out_vld", {15'b0, bus.out_vld}, 16'h0);
        check("idle_outp_q", {15'b0, bus.outp_q}, 16'h0);

        // T3: capture then hold
        @(negedge clk);
        drive(16'h8000, 4'd15, 1'b1);
        tick();
        check("t3_outp_q_cap", {15'b0, bus.outp_q}, 16'h1);
        check("t3_out_vld_cap", {15'b0, bus.out_vld}, 16'h1);
        @(negedge clk);
        drive(16'h0000, 4'd15, 1'b0);
        tick();
        check("t3_outp_q_hold", {15'b0, bus.outp_q}, 16'h1);
        check("t3_out_vld_drop", {15'b0, bus.out_vld}, 16'h0);
        check("t3_outp_comb", {15'b0, bus.outp}, 16'h0);

        // T4: async reset between edges, outp still live
        #2;
        rst_n = 1'b0;
        #1;
        check("t4_outp_q_rst", {15'b0, bus.outp_q}, 16'h0);
        check("t4_out_vld_rst", {15'b0, bus.out_vld}, 16'h0);
        drive(16'h0004, 4'd2, 1'b0); #1;
        check("t4_outp_in_rst", {15'b0, bus.outp}, 16'h1);
        // Sample offered during reset is discarded
        drive(16'hffff, 4'd0, 1'b1);
        tick();
        check("t4_discard_q", {15'b0, bus.outp_q}, 16'h0);
        check("t4_discard_vld", {15'b0, bus.out_vld}, 16'h0);
        @(negedge clk);
        rst_n = 1'b1;
        drive(16'hffff, 4'd0, 1'b0);
        tick();
        check("t4_post_idle_vld", {15'b0, bus.out_vld}, 16'h0);
        check("t4_post_idle_q", {15'b0, bus.outp_q}, 16'h0);
        @(negedge clk);
        drive(16'h0001, 4'd0, 1'b1);
        tick();
        check("t4_first_cap_q", {15'b0, bus.outp_q}, 16'h1);
        check("t4_first_cap_vld", {15'b0, bus.out_vld}, 16'h1);

`ifdef MUX16TO1_ONEHOT_EN
        // T6: one-hot decode and its reset
        @(negedge clk);
        drive(16'h0080, 4'h7, 1'b1);
        tick();
        check("t6_sel_oh_q", bus.sel_oh_q, 16'h0080);
        check("t6_outp_q", {15'b0, bus.outp_q}, 16'h1);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_sel_oh_rst", bus.sel_oh_q, 16'h0000);
        @(negedge clk);
        rst_n = 1'b1;
`endif

        // T5: full sweep, combinational and registered
        for (int k = 0; k < 2; k++) begin
            for (int s = 0; s < 16; s++) begin
                @(negedge clk);
                w = words[k];
                e = 1'((w >> s) & 16'h1);
                drive(w, 4'(s), 1'b1);
                exp_q.push_back(e);
                word_q.push_back(w);
                #1;
                check($sformatf("t5_outp_w%0d_s%0d", k, s), {15'b0, bus.outp}, {15'b0, e});
                tick();
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $error("FAIL t5_queue_empty observed=0 expected=1");
                end else begin
                    e = exp_q.pop_front();
                    w = word_q.pop_front();
                    check($sformatf("t5_outp_q_w%0d_s%0d", k, s), {15'b0, bus.outp_q}, {15'b0, e});
                    check($sformatf("t5_vld_w%0d_s%0d", k, s), {15'b0, bus.out_vld}, 16'h1);
`ifdef MUX16TO1_ONEHOT_EN
                    check($sformatf("t5_oh_w%0d_s%0d", k, s), bus.sel_oh_q, 16'h0001 << s);
                    check($sformatf("t5_inv_w%0d_s%0d", k, s), {15'b0, |(bus.sel_oh_q & w)}, {15'b0, bus.outp_q});
`endif
                end
            end
        end

        // Strobe drops: value held, valid cleared
        @(negedge clk);
        bus.in_vld = 1'b0;
        bus.inp    = 16'h0000;
        tick();
        check("end_out_vld", {15'b0, bus.out_vld}, 16'h0);
        check("end_outp_q_hold", {15'b0, bus.outp_q}, {15'b0, words[1][15]});

        // ---------------- final report ----------------
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
